// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read handshake, IR handoff and redirect.
// master = fetch unit, slave = memory/decode side.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir_out;
  logic [63:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] fetch_count;

  modport master (
    output imem_req, imem_addr, ir_out, ir_pc, ir_valid, fetch_count,
    input  imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, ir_out, ir_pc, ir_valid, fetch_count,
    output imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle RISC-V front end: owns the PC, fetches one word per instruction,
// holds it in the IR until decode takes it, and squashes in-flight reads on redirect.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_unit_if.master  bus
);
  typedef enum logic [1:0] {REQ, HOLD, DRAIN} state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [31:0] ir, ir_n;
  logic [63:0] ir_pc, ir_pc_n;
  logic        ir_valid, ir_valid_n;
  logic [31:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= REQ;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
      cnt      <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    cnt_n      = cnt;
    if (bus.redirect) begin
      pc_n       = {bus.redirect_pc[63:2], 2'b00};
      ir_valid_n = 1'b0;
      unique case (state)
        // A read left unacked is still in flight and its response must be dropped.
        REQ:     state_n = bus.imem_ack ? REQ : DRAIN;
        HOLD: begin
          state_n = REQ;
          if (bus.ir_ready) cnt_n = cnt + 32'd1;
        end
        DRAIN:   state_n = bus.imem_ack ? REQ : DRAIN;
        default: state_n = REQ;
      endcase
    end else begin
      unique case (state)
        REQ: if (bus.imem_ack) begin
          ir_n       = bus.imem_rdata;
          ir_pc_n    = pc;
          pc_n       = pc + 64'(PC_STEP);
          ir_valid_n = 1'b1;
          state_n    = HOLD;
        end
        HOLD: if (bus.ir_ready) begin
          ir_valid_n = 1'b0;
          cnt_n      = cnt + 32'd1;
          state_n    = REQ;
        end
        DRAIN:   if (bus.imem_ack) state_n = REQ;
        default: state_n = REQ;
      endcase
    end
  end

  // DRAIN keeps the request up at the new PC so memory sees no gap.
  assign bus.imem_req    = (state != HOLD);
  assign bus.imem_addr   = pc;
  assign bus.ir_out      = ir;
  assign bus.ir_pc       = ir_pc;
  assign bus.ir_valid    = ir_valid;
  assign bus.fetch_count = cnt;
endmodule
